// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multiply/divide sequencer for the Execute stage (MULT/MULTU/DIV/DIVU -> {hi,lo}).
// Latency: MUL ok_o returns MUL_LAT+1 cycles after accept; DIV ok_o returns 34 cycles after accept.
// Backpressure: ok_o=0 stalls E while busy; the result is held in DONE until e_stall_i drops.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   valid_i, op_i      request from E (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a_i, b_i           rs / rt operands, captured at accept
//   e_stall_i          E held by another cause; keeps the block in DONE
//   flush_i            kill the in-flight operation, result registers untouched
//   ok_o, busy_o       mult_ok to the hazard unit, state != IDLE
//   hi_o, lo_o         result (remainder / quotient for divides)
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        e_stall_i,
    input  logic        flush_i,
    output logic        ok_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d;        // operand signs, already masked to 0 for unsigned ops
    logic        sb_q, sb_d;
    logic [31:0] abs_a_q, abs_a_d;
    logic [31:0] abs_b_q, abs_b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;      // starts as |a| and shifts quotient bits in from the right
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Multiply on magnitudes, then restore the sign for MULT.
    logic [63:0] prod_mag;
    logic [63:0] prod;
    assign prod_mag = {32'b0, abs_a_q} * {32'b0, abs_b_q};
    assign prod     = (sa_q ^ sb_q) ? -prod_mag : prod_mag;

    // One restoring-division step.
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    always_comb begin
        div_sh   = {rem_q, quo_q[31]};
        div_diff = div_sh - {1'b0, abs_b_q};
        if (div_diff[32]) begin
            step_rem = div_sh[31:0];
            step_quo = {quo_q[30:0], 1'b0};
        end else begin
            step_rem = div_diff[31:0];
            step_quo = {quo_q[30:0], 1'b1};
        end
    end

    // Sign fix-up. With b=0 the restoring loop leaves |a| in the remainder,
    // so the sign fix already yields hi=a; only the quotient needs forcing.
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;
    always_comb begin
        rem_fix = sa_q ? -rem_q : rem_q;
        if (abs_b_q == 32'd0) begin
            quo_fix = 32'hFFFF_FFFF;
        end else begin
            quo_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        abs_a_d = abs_a_q;
        abs_b_d = abs_b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    sa_d    = ~op_i[0] & a_i[31];
                    sb_d    = ~op_i[0] & b_i[31];
                    abs_a_d = sa_d ? -a_i : a_i;
                    abs_b_d = sb_d ? -b_i : b_i;
                    quo_d   = abs_a_d;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = op_i[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = rem_fix;
                lo_d    = quo_fix;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Leave only once the instruction actually moves out of E.
                if (!e_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush overrides everything, including a completion on this edge.
        if (flush_i) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            abs_a_q <= 32'd0;
            abs_b_q <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            abs_a_q <= abs_a_d;
            abs_b_q <= abs_b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:  ok_o = ~(valid_i & ~flush_i);
            S_DONE:  ok_o = 1'b1;
            default: ok_o = 1'b0;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk;
    logic        resetn;
    logic        valid_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        e_stall_i;
    logic        flush_i;
    logic        ok_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks;
    int n_errors;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_i   (valid_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .e_stall_i (e_stall_i),
        .flush_i   (flush_i),
        .ok_o      (ok_o),
        .busy_o    (busy_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, count ok_o-low cycles (accept cycle included),
    // check the result, optionally hold e_stall_i in DONE, then retire it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int hold);
        int  n;
        bit  done;
        op_i      = op;
        a_i       = a;
        b_i       = b;
        valid_i   = 1'b1;
        e_stall_i = (hold > 0);
        #1;
        n    = 1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            a_i = ~a;                     // latched copies must be used
            b_i = b ^ 32'h5A5A_5A5A;
            #1;
            if (ok_o) done = 1'b1;
            else n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
        chk({tag, " busy in done"}, 64'(busy_o), 64'd1);
        for (int h = 0; h < hold; h++) begin
            step();
            #1;
            chk({tag, " hold ok"}, 64'(ok_o), 64'd1);
            chk({tag, " hold busy"}, 64'(busy_o), 64'd1);
            chk({tag, " hold lo"}, 64'(lo_o), 64'(exp_lo));
        end
        e_stall_i = 1'b0;
        step();
        valid_i = 1'b0;
        #1;
        chk({tag, " idle after"}, 64'(busy_o), 64'd0);
        chk({tag, " ok after"}, 64'(ok_o), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b1;
        valid_i   = 1'b0;
        op_i      = 2'b00;
        a_i       = 32'd0;
        b_i       = 32'd0;
        e_stall_i = 1'b0;
        flush_i   = 1'b0;
        #2 resetn = 1'b0;
        #2;
        chk("reset hi", 64'(hi_o), 64'd0);
        chk("reset lo", 64'(lo_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset ok", 64'(ok_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Multiplies
        run_op("MULT -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_op("MULTU max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,
               32'hFFFF_FFFE, 32'h0000_0001, 3);

        // Divides
        run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0);
        run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 0);
        run_op("DIVU by0", 2'b11, 32'h0000_1234, 32'd0, 34, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        run_op("DIV -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 34, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

        // Flush mid-divide: result registers keep the -5/0 result
        op_i    = 2'b11;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        valid_i = 1'b1;
        #1;
        chk("flush accept ok", 64'(ok_o), 64'd0);
        for (int i = 0; i < 10; i++) step();
        flush_i = 1'b1;
        #1;
        chk("flush in div ok", 64'(ok_o), 64'd0);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("flush busy", 64'(busy_o), 64'd0);
        chk("flush ok", 64'(ok_o), 64'd1);
        chk("flush hi kept", 64'(hi_o), 64'hFFFF_FFFB);
        chk("flush lo kept", 64'(lo_o), 64'hFFFF_FFFF);
        run_op("MULTU 3*4", 2'b01, 32'd3, 32'd4, 3, 32'd0, 32'd12, 0);

        // Request arriving together with a flush in IDLE is dropped
        op_i    = 2'b00;
        a_i     = 32'd9;
        b_i     = 32'd9;
        valid_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush+req ok", 64'(ok_o), 64'd1);
        step();
        valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("flush+req busy", 64'(busy_o), 64'd0);
        chk("flush+req lo", 64'(lo_o), 64'd12);

        // Asynchronous reset in the middle of a divide
        op_i    = 2'b10;
        a_i     = 32'hFFFF_FF9C;
        b_i     = 32'd7;
        valid_i = 1'b1;
        for (int i = 0; i < 21; i++) step();
        #1;
        chk("pre-reset busy", 64'(busy_o), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid reset hi", 64'(hi_o), 64'd0);
        chk("mid reset lo", 64'(lo_o), 64'd0);
        chk("mid reset busy", 64'(busy_o), 64'd0);
        valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        #1;
        chk("post reset ok", 64'(ok_o), 64'd1);
        chk("post reset busy", 64'(busy_o), 64'd0);
        run_op("MULT 7*-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the shared multiply/divide resource in the Execute stage of the 5-stage MIPS pipeline.
- Accepts one MULT/MULTU/DIV/DIVU operation from E, runs it to completion, and presents a 64-bit {hi,lo} result.
- Drives the mult_ok signal the hazard unit uses to stall E and bubble M.
- Multiply runs for a fixed, parameterised latency. Divide is a 32-step iterative restoring divider owned by this block.

Parameters:
- MUL_LAT, 2: number of MUL-state cycles before the product is presented (legal range 1..8).

Ports:
- clk        input   1   clock
- resetn     input   1   asynchronous active-low reset
- valid_i    input   1   E holds a mult/div instruction
- op_i       input   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a_i        input   32  rs operand (dividend / multiplicand); held stable by the E stall while the block is busy
- b_i        input   32  rt operand (divisor / multiplier)
- e_stall_i  input   1   E held by causes other than this block (e.g. ~d_data_ok)
- flush_i    input   1   exception/eret flush of E
- ok_o       output  1   mult_ok to the hazard unit; 0 = hold E and bubble M
- busy_o     output  1   state != IDLE
- hi_o       output  32  result high word (remainder for div)
- lo_o       output  32  result low word (quotient for div)

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE. Reset gives IDLE, hi_o=lo_o=0, busy_o=0, ok_o=1.
- ok_o (combinational):
  - 0 when (IDLE & valid_i & ~flush_i), or state is MUL, DIV or FIX.
  - 1 in IDLE without a new request, and in DONE.
- IDLE:
  - valid_i & ~flush_i latches op, a, b (signs, absolute values for signed ops).
  - op[1]=0 goes to MUL; op[1]=1 goes to DIV with step counter=0.
- MUL:
  - Counter runs 0..MUL_LAT-1, then DONE.
  - Product is 64-bit: signed for MULT, unsigned for MULTU. hi=product[63:32], lo=product[31:0].
- DIV:
  - One restoring step per cycle on magnitudes: remainder shift-left, trial subtract, quotient bit set.
  - 32 cycles, then FIX.
- FIX:
  - Signed case: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Writes hi/lo, then DONE.
- Divide-by-zero (b=0, any div op): lo=0xFFFFFFFF, hi=a_i. Same FIX timing.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DONE:
  - hi_o/lo_o are valid and ok_o=1.
  - Goes to IDLE when ~e_stall_i (the instruction leaves E). Otherwise stays in DONE.
  - DONE never re-launches from the same valid_i.
- Latency, with the accept edge at the end of cycle t:
  - MUL: ok_o=1 in cycle t+MUL_LAT+1.
  - DIV: ok_o=1 in cycle t+34 (32 DIV + 1 FIX).
- hi_o/lo_o change only on the FIX→DONE or MUL→DONE transition. They hold until the next completion. They are not cleared by flush.
- flush_i in any state gives IDLE next edge, no hi/lo update, ok_o=1 the following cycle.
  - flush_i together with a new request in IDLE: the request is ignored.
- Reset asserted mid-operation: immediate IDLE and zeroed outputs. No partial result escapes.
- Operands are used only from the latched copies after acceptance. Changes on a_i/b_i are ignored.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, MUL_LAT=2 -> ok_o low 3 cycles incl. accept; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, ok_o=1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Hold e_stall_i=1 for 3 cycles in DONE -> ok_o stays 1, no relaunch, IDLE after release.
- DIVU 100/7 -> ok_o=1 exactly 34 cycles after accept; lo=0x0000000E, hi=0x00000002. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234.
- Start DIVU, assert flush_i at step 10 -> IDLE next cycle, ok_o=1, hi/lo keep the previous result. A new MULTU 3*4 right after -> hi=0, lo=12.
- Drop resetn low at step 20 of a DIV -> hi_o=lo_o=0 and busy_o=0 asynchronously. After release, ok_o=1 and the block is idle.
